// File: rtl/compl_pkg.sv
// Shared widths, ROM quarter-turn offset and FSM encoding for the complex
// cos/sin scheduler.
package compl_pkg;
   localparam int ANGLE_W = 12;
   localparam int DATA_W  = 16;
   localparam logic [ANGLE_W-1:0] QUARTER = 12'd1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COS  = 2'd1,
      ST_SIN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// last+1 with wrap. The pointer register lives in the caller.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);
   logic [IDW-1:0] w_cand;

   always_comb begin
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      w_cand = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = IDW'((int'(last) + k) % NREQ);
         if (enable && !any && req[w_cand]) begin
            any           = 1'b1;
            grant[w_cand] = 1'b1;
            idx           = w_cand;
         end
      end
   end
endmodule

// File: rtl/compl_sched.sv
// Round-robin scheduler sharing one cos ROM: cos(a) then cos(a-1024) = sin(a).
// Define COMPL_SCHED_PRIO0_EN to give requester 0 fixed absolute priority.
module compl_sched
   import compl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_i,
   input  logic [ANGLE_W*NREQ-1:0]   angle_i,
   output logic [ANGLE_W-1:0]        rom_angle_o,
   input  logic [DATA_W-1:0]         rom_data_i,
   output logic [DATA_W-1:0]         r_o,
   output logic [DATA_W-1:0]         i_o,
   output logic [IDW-1:0]            id_o,
   output logic                      valid_o,
   output logic [NREQ-1:0]           done_o,
   output logic                      busy_o
);
   state_t               r_state;
   logic [ANGLE_W-1:0]   r_angle_q;
   logic [IDW-1:0]       r_gid;
   logic [IDW-1:0]       r_last;
   logic [DATA_W-1:0]    r_rq;

   logic [NREQ-1:0]      w_arb_req;
   logic [NREQ-1:0]      w_arb_gnt;
   logic [IDW-1:0]       w_arb_idx;
   logic                 w_arb_any;
   logic                 w_take0;
   logic                 w_gnt;
   logic [IDW-1:0]       w_gidx;
   logic [ANGLE_W-1:0]   w_angle_sel;

`ifdef COMPL_SCHED_PRIO0_EN
   // Requester 0 bypasses the ring; the rest rotate among themselves.
   assign w_take0   = req_i[0];
   assign w_arb_req = {req_i[NREQ-1:1], 1'b0};
`else
   assign w_take0   = 1'b0;
   assign w_arb_req = req_i;
`endif

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req    (w_arb_req),
      .last   (r_last),
      .enable (r_state == ST_IDLE),
      .grant  (w_arb_gnt),
      .idx    (w_arb_idx),
      .any    (w_arb_any)
   );

   assign w_gnt  = w_take0 | w_arb_any;
   assign w_gidx = w_take0 ? '0 : w_arb_idx;

   always_comb begin
      w_angle_sel = '0;
      for (int k = 0; k < NREQ; k++)
         if (w_gidx == IDW'(k)) w_angle_sel = angle_i[ANGLE_W*k +: ANGLE_W];
   end

   assign rom_angle_o = (r_state == ST_SIN) ? r_angle_q - QUARTER : r_angle_q;
   assign busy_o      = (r_state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_angle_q <= '0;
         r_gid     <= '0;
         r_last    <= IDW'(NREQ-1);
         r_rq      <= '0;
         r_o       <= '0;
         i_o       <= '0;
         id_o      <= '0;
         valid_o   <= 1'b0;
         done_o    <= '0;
      end else begin
         valid_o <= 1'b0;
         done_o  <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt) begin
                  r_angle_q <= w_angle_sel;
                  r_gid     <= w_gidx;
                  if (!w_take0) r_last <= w_arb_idx;
                  r_state   <= ST_COS;
               end
            end
            ST_COS: begin
               r_rq    <= rom_data_i;
               r_state <= ST_SIN;
            end
            // Publish at the SIN exit so results and pulses are visible in DONE.
            ST_SIN: begin
               r_o     <= r_rq;
               i_o     <= rom_data_i;
               id_o    <= r_gid;
               valid_o <= 1'b1;
               done_o  <= {{(NREQ-1){1'b0}}, 1'b1} << r_gid;
               r_state <= ST_DONE;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_compl_sched.sv
// Directed bench for compl_sched with a rounded cos ROM model.
module tb_compl_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_i;
   logic [12*NREQ-1:0]   angle_i;
   logic [11:0]          rom_angle_o;
   logic [15:0]          rom_data_i;
   logic [15:0]          r_o, i_o;
   logic [IDW-1:0]       id_o;
   logic                 valid_o;
   logic [NREQ-1:0]      done_o;
   logic                 busy_o;

   int n_tot = 0;
   int n_bad = 0;

   compl_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req_i),
      .angle_i     (angle_i),
      .rom_angle_o (rom_angle_o),
      .rom_data_i  (rom_data_i),
      .r_o         (r_o),
      .i_o         (i_o),
      .id_o        (id_o),
      .valid_o     (valid_o),
      .done_o      (done_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] cos_rom(input logic [11:0] a);
      real x;
      x = $cos(2.0 * 3.14159265358979 * real'(a) / 4096.0) * 32767.0;
      return 16'($rtoi($floor(x + 0.5)));
   endfunction

   always_comb rom_data_i = cos_rom(rom_angle_o);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Single requester transaction with an angle change after grant.
   task automatic run_one(input int id, input logic [11:0] ang, input logic [11:0] sin_ang,
                          input bit chk_data, input logic [15:0] er, input logic [15:0] ei);
      req_i[id] = 1'b1;
      angle_i[12*id +: 12] = ang;
      tick;
      chk("cos_angle", 32'(rom_angle_o), 32'(ang));
      chk("busy_cos", 32'(busy_o), 32'd1);
      angle_i[12*id +: 12] = ~ang;
      tick;
      chk("sin_angle", 32'(rom_angle_o), 32'(sin_ang));
      chk("valid_sin", 32'(valid_o), 32'd0);
      tick;
      chk("valid_done", 32'(valid_o), 32'd1);
      chk("done_onehot", 32'(done_o), 32'(4'b0001 << id));
      chk("id", 32'(id_o), 32'(id));
      if (chk_data) begin
         chk("r", 32'(r_o), 32'(er));
         chk("i", 32'(i_o), 32'(ei));
      end
      req_i[id] = 1'b0;
      tick;
      chk("valid_idle", 32'(valid_o), 32'd0);
      chk("done_idle", 32'(done_o), 32'd0);
      chk("busy_idle", 32'(busy_o), 32'd0);
      if (chk_data) chk("r_hold", 32'(r_o), 32'(er));
   endtask

   logic [11:0] rr_ang [4] = '{12'h000, 12'd1024, 12'd512, 12'hFFF};
   logic [11:0] rr_sin [4] = '{12'hC00, 12'h000, 12'hE00, 12'hBFF};
   logic [15:0] rr_r   [4] = '{16'h7FFF, 16'h0000, 16'h5A82, 16'h7FFF};
   logic [15:0] rr_i   [4] = '{16'h0000, 16'h7FFF, 16'h5A82, 16'hFFCE};

   initial begin
      reset   = 1'b1;
      req_i   = '0;
      angle_i = '0;
      repeat (2) tick;
      chk("rst_r", 32'(r_o), 32'd0);
      chk("rst_i", 32'(i_o), 32'd0);
      chk("rst_id", 32'(id_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_rom_angle", 32'(rom_angle_o), 32'd0);
      reset = 1'b0;
      tick;
      chk("idle_no_req", 32'(busy_o), 32'd0);

      run_one(0, 12'd0,    12'hC00, 1'b1, 16'h7FFF, 16'h0000);
      run_one(0, 12'd1024, 12'h000, 1'b1, 16'h0000, 16'h7FFF);
      run_one(0, 12'd512,  12'hE00, 1'b1, 16'h5A82, 16'h5A82);
      run_one(0, 12'd100,  12'hC64, 1'b0, 16'h0000, 16'h0000);
      run_one(0, 12'hFFF,  12'hBFF, 1'b1, 16'h7FFF, 16'hFFCE);

      // All four requesting from reset: served 0,1,2,3 at 4-cycle spacing.
      reset = 1'b1;
      tick;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) angle_i[12*k +: 12] = rr_ang[k];
      req_i = 4'b1111;
      for (int s = 0; s < 4; s++) begin
         repeat ((s == 0) ? 2 : 3) tick;
         chk("rr_sin_angle", 32'(rom_angle_o), 32'(rr_sin[s]));
         tick;
         chk("rr_done", 32'(done_o), 32'(4'b0001 << s));
         chk("rr_id", 32'(id_o), 32'(s));
         chk("rr_r", 32'(r_o), 32'(rr_r[s]));
         chk("rr_i", 32'(i_o), 32'(rr_i[s]));
         req_i[s] = 1'b0;
      end
      tick;

      // Requester 2 stays high after its done: 3 must be served before 2 again.
      reset = 1'b1;
      tick;
      reset = 1'b0;
      req_i = 4'b1100;
      repeat (3) tick;
      chk("keep_first", 32'(id_o), 32'd2);
      repeat (4) tick;
      chk("keep_second", 32'(id_o), 32'd3);
      chk("keep_second_done", 32'(done_o), 32'b1000);
      req_i[3] = 1'b0;
      repeat (4) tick;
      chk("keep_third", 32'(id_o), 32'd2);
      req_i[2] = 1'b0;
      tick;

      // Reset during SIN aborts the transaction with no done pulse.
      req_i = 4'b0001;
      tick;
      tick;
      chk("pre_abort_sin", 32'(rom_angle_o), 32'hC00);
      reset = 1'b1;
      #1;
      chk("abort_valid", 32'(valid_o), 32'd0);
      chk("abort_r", 32'(r_o), 32'd0);
      chk("abort_i", 32'(i_o), 32'd0);
      chk("abort_done", 32'(done_o), 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      req_i = '0;
      tick;
      reset = 1'b0;
      repeat (3) tick;
      chk("abort_no_valid", 32'(valid_o), 32'd0);

      req_i = 4'b0011;
      repeat (3) tick;
      chk("post_rst_first", 32'(done_o), 32'b0001);
      req_i[0] = 1'b0;
      repeat (4) tick;
      chk("post_rst_second", 32'(id_o), 32'd1);
      req_i[1] = 1'b0;
      tick;

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
